// File: rtl/sync_ram_port_ctrl.sv
// Request/response front end for one port of a 1-cycle-latency synchronous RAM.
// Read data lands in a 2-entry response FIFO, so clients get full backpressure.
module sync_ram_port_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_data,
  output logic [AWIDTH-1:0] resp_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_d,
  input  logic [DWIDTH-1:0] ram_q
);

  logic              rd_pend_q, rd_pend_d;
  logic [AWIDTH-1:0] pend_addr_q, pend_addr_d;
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic [1:0]        count_q, count_d;
  logic [DWIDTH-1:0] fdata_q [2];
  logic [AWIDTH-1:0] faddr_q [2];

  logic       fire, push, pop;
  logic [1:0] occ;

  always_comb begin
    pop        = (count_q != 2'd0) && resp_ready;
    push       = rd_pend_q;
    occ        = {1'b0, rd_pend_q} + count_q;
    // occ counts the in-flight read, so a push can never meet a full FIFO
    req_ready  = !rst && ((occ < 2'd2) || pop);
    fire       = req_valid && req_ready;
    ram_en     = fire;
    ram_we     = fire && req_we;
    ram_addr   = req_addr;
    ram_d      = req_wdata;
    resp_valid = (count_q != 2'd0);
    resp_data  = fdata_q[rptr_q];
    resp_addr  = faddr_q[rptr_q];
  end

  always_comb begin
    rd_pend_d   = fire && !req_we;
    pend_addr_d = pend_addr_q;
    if (fire && !req_we) pend_addr_d = req_addr;
    wptr_d  = push ? ~wptr_q : wptr_q;
    rptr_d  = pop ? ~rptr_q : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q   <= 1'b0;
      pend_addr_q <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      pend_addr_q <= pend_addr_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fdata_q[wptr_q] <= ram_q;
      faddr_q[wptr_q] <= pend_addr_q;
    end
  end

  always @(posedge clk) begin
    if (!rst && push && !pop) assert (count_q != 2'd2);
  end

endmodule

// File: tb/tb_sync_ram_port_ctrl.sv
// Bench for sync_ram_port_ctrl: RAM model plus a response scoreboard.
// Driver acts on negedge, checks at +3; the monitor scores at +4.
module tb_sync_ram_port_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       resp_valid, resp_ready;
  logic [7:0] resp_data, resp_addr;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_d, ram_q;

  logic [7:0]  mem    [256];
  logic [7:0]  golden [256];
  logic [15:0] sb [$];

  int n_chk  = 0;
  int n_pass = 0;

  sync_ram_port_ctrl #(.DWIDTH(8), .AWIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_addr(resp_addr),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_d(ram_d), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_d;
      else ram_q <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    #4;
    if (rst) begin
      sb.delete();
    end else begin
      if (resp_valid && resp_ready) begin
        chk("resp_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rdata", resp_data, e[7:0]);
          chk("raddr", resp_addr, e[15:8]);
        end
      end
      if (req_valid && req_ready) begin
        chk("ram_en", ram_en, 1);
        chk("ram_we", ram_we, req_we);
        chk("ram_addr", ram_addr, req_addr);
        if (req_we) golden[req_addr] = req_wdata;
        else sb.push_back({req_addr, golden[req_addr]});
      end else if (ram_en) begin
        chk("ram_en_nofire", ram_en, 0);
      end
    end
  end

  task automatic do_req(input logic we, input logic [7:0] a,
                        input logic [7:0] d, input bit rnd);
    int  n = 0;
    bit  done = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = a;
      req_wdata  = d;
      resp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      done = req_ready;
      n++;
    end
    chk("req_accept", 32'(done), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      #3;
      if (sb.size() == 0 && !resp_valid) break;
    end
    chk("drain_empty", 32'(sb.size()), 0);
    chk("drain_idle", resp_valid, 0);
  endtask

  initial begin
    logic [7:0] hold;
    int nf;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i) ^ 8'h3C;
      golden[i] = 8'(i) ^ 8'h3C;
    end
    ram_q = 8'h00;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00;
    resp_ready = 1'b0;
    hold = 8'h00;

    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #3;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_req_ready", req_ready, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_valid", resp_valid, 0);

    do_req(1'b1, 8'h10, 8'hA5, 1'b0);
    chk("wr_ram_we", ram_we, 1);
    do_req(1'b0, 8'h10, 8'h00, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    chk("rb_lat1", resp_valid, 0);
    @(negedge clk);
    #3;
    chk("rb_lat2", resp_valid, 1);
    chk("rb_data", resp_data, 8'hA5);
    chk("rb_addr", resp_addr, 8'h10);
    @(negedge clk);
    #3;
    chk("rb_single", resp_valid, 0);

    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      req_valid  = (c < 16);
      req_we     = 1'b0;
      req_addr   = 8'(c);
      resp_ready = 1'b1;
      #3;
      if (c < 16) chk("stream_ready", req_ready, 1);
      if (c >= 2 && c < 18) chk("stream_valid", resp_valid, 1);
      if (c == 18) chk("stream_end", resp_valid, 0);
    end

    nf = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_addr   = 8'h20 + 8'(nf);
      resp_ready = 1'b0;
      #3;
      if (req_ready) nf++;
      if (c == 2) hold = resp_data;
      if (c >= 3) begin
        chk("bp_ready_low", req_ready, 0);
        chk("bp_hold", resp_data, hold);
      end
    end
    chk("bp_accepted", nf, 2);
    @(negedge clk);
    req_addr   = 8'h20 + 8'(nf);
    resp_ready = 1'b1;
    #3;
    chk("bp_pop_ready", req_ready, 1);
    chk("bp_pop_data", resp_data, 8'h20 ^ 8'h3C);
    if (req_ready) nf++;
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    #3;
    chk("bp_one_more", nf, 3);
    drain();

    for (int k = 0; k < 8; k++) begin
      logic [7:0] a, v;
      a = 8'h40 + 8'(k * 3);
      v = 8'($urandom);
      do_req(1'b1, a, v, 1'b1);
      do_req(1'b0, a, 8'h00, 1'b1);
    end
    drain();

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h30;
    resp_ready = 1'b0;
    @(negedge clk);
    req_addr = 8'h31;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #3;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_ram_en", ram_en, 0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_ready_after", req_ready, 1);
    do_req(1'b0, 8'h10, 8'h00, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    chk("mid_lat1", resp_valid, 0);
    @(negedge clk);
    #3;
    chk("mid_lat2", resp_valid, 1);
    chk("mid_data", resp_data, 8'hA5);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
